// File: rtl/display_pkg.sv
// Shared types and defaults for the multiplexed 7-segment display scheduler.
package display_pkg;

    localparam int unsigned DISP_W           = 16;
    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned N_REQ_DEF        = 3;
    localparam int unsigned HOLD_CYCLES_DEF  = 50_000_000;
    localparam int unsigned BLANK_CYCLES_DEF = 5_000_000;
    localparam int unsigned CNT_W_DEF        = 26;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requesting source after ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    int unsigned idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!any_req && req[idx[PTR_W-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates requesters onto one 4-digit display: hold, blank gap,
// and urgent preemption by source 0. All outputs are registered.
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned N_REQ        = N_REQ_DEF,
    parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic                    clk0,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [DISP_W*N_REQ-1:0] data,
    output logic [DISP_W-1:0]       disp_val,
    output logic                    disp_ena,
    output logic [N_REQ-1:0]        gnt,
    output logic [2:0]              cur_src,
    output logic                    done
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE        = N_REQ'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DISP_W-1:0]  disp_val_q, disp_val_d;
    logic               disp_ena_q, disp_ena_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [2:0]         cur_src_q, cur_src_d;
    logic               done_q, done_d;

    logic [PTR_W-1:0]   winner;
    logic               any_req;
    logic               load;
    logic [PTR_W-1:0]   load_idx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        disp_val_d = disp_val_q;
        disp_ena_d = disp_ena_q;
        gnt_d      = '0;
        cur_src_d  = cur_src_q;
        done_d     = 1'b0;
        load       = 1'b0;
        load_idx   = winner;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    load = 1'b1;
                end
            end
            SHOW: begin
                if (cur_src_q != '0 && req[0]) begin
                    load     = 1'b1;
                    load_idx = '0;
                end else if (cnt_q == '0) begin
                    disp_ena_d = 1'b0;
                    if (BLANK_CYCLES > 0) begin
                        state_d = BLANK;
                        cnt_d   = BLANK_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    // done is registered, so raise it one cycle ahead to land on cnt==0
                    done_d = (cnt_q == CNT_W'(1));
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d    = SHOW;
            cnt_d      = HOLD_LOAD;
            disp_val_d = data[DISP_W*32'(load_idx) +: DISP_W];
            cur_src_d  = 3'(load_idx);
            gnt_d      = ONE << load_idx;
            ptr_d      = load_idx;
            disp_ena_d = 1'b1;
            done_d     = (HOLD_CYCLES == 1);
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= PTR_W'(N_REQ - 1);
            disp_val_q <= '0;
            disp_ena_q <= 1'b0;
            gnt_q      <= '0;
            cur_src_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            disp_val_q <= disp_val_d;
            disp_ena_q <= disp_ena_d;
            gnt_q      <= gnt_d;
            cur_src_q  <= cur_src_d;
            done_q     <= done_d;
        end
    end

    assign disp_val = disp_val_q;
    assign disp_ena = disp_ena_q;
    assign gnt      = gnt_q;
    assign cur_src  = cur_src_q;
    assign done     = done_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Two schedulers (blank gap 2 and 0) driven in parallel against a
// timestamp-based reference model of the display timeline.
module tb_display_scheduler;

    localparam int N = 3;
    localparam int H = 4;

    logic        clk0 = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [47:0] data;

    logic [15:0] val_a, val_b;
    logic        ena_a, ena_b;
    logic [2:0]  gnt_a, gnt_b;
    logic [2:0]  src_a, src_b;
    logic        done_a, done_b;

    display_scheduler #(
        .N_REQ(3), .HOLD_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(4)
    ) dut_a (
        .clk0(clk0), .rst(rst), .req(req), .data(data),
        .disp_val(val_a), .disp_ena(ena_a), .gnt(gnt_a), .cur_src(src_a), .done(done_a)
    );

    display_scheduler #(
        .N_REQ(3), .HOLD_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(4)
    ) dut_b (
        .clk0(clk0), .rst(rst), .req(req), .data(data),
        .disp_val(val_b), .disp_ena(ena_b), .gnt(gnt_b), .cur_src(src_b), .done(done_b)
    );

    always #5 clk0 = ~clk0;

    logic [15:0] o_val  [2];
    logic        o_ena  [2];
    logic [2:0]  o_gnt  [2];
    logic [2:0]  o_src  [2];
    logic        o_done [2];
    assign o_val[0] = val_a;   assign o_val[1] = val_b;
    assign o_ena[0] = ena_a;   assign o_ena[1] = ena_b;
    assign o_gnt[0] = gnt_a;   assign o_gnt[1] = gnt_b;
    assign o_src[0] = src_a;   assign o_src[1] = src_b;
    assign o_done[0] = done_a; assign o_done[1] = done_b;

    // Model: each display instance is a timeline of grant timestamps.
    int          bl    [2];
    bit          m_has [2];
    int          m_g   [2];
    int          m_arb [2];
    int          m_src [2];
    int          m_ptr [2];
    logic [15:0] m_val [2];
    int          cyc;
    int          checks;
    int          errors;

    function automatic bit showing(int i);
        return m_has[i] && cyc >= m_g[i] && cyc < m_g[i] + H;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic grant(input int i, input int s);
        m_has[i] = 1'b1;
        m_src[i] = s;
        m_val[i] = data[16*s +: 16];
        m_ptr[i] = s;
        m_g[i]   = cyc + 1;
        m_arb[i] = cyc + 1 + H + bl[i];
    endtask

    task automatic advance(input int i);
        int  s;
        bit  found;
        found = 1'b0;
        if (showing(i) && m_src[i] != 0 && req[0]) begin
            grant(i, 0);
        end else if (!showing(i) && cyc >= m_arb[i] && req != 3'b000) begin
            for (int k = 1; k <= N; k++) begin
                s = (m_ptr[i] + k) % N;
                if (!found && req[s]) begin
                    found = 1'b1;
                    grant(i, s);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_has[i] = 1'b0;
            m_src[i] = 0;
            m_val[i] = 16'h0000;
            m_ptr[i] = N - 1;
            m_g[i]   = -100;
            m_arb[i] = 0;
        end
    endtask

    task automatic check_all();
        logic [2:0] eg;
        for (int i = 0; i < 2; i++) begin
            eg = (m_has[i] && cyc == m_g[i]) ? 3'(1 << m_src[i]) : 3'b000;
            chk($sformatf("ena%0d", i),  32'(o_ena[i]),  32'(showing(i)));
            chk($sformatf("gnt%0d", i),  32'(o_gnt[i]),  32'(eg));
            chk($sformatf("val%0d", i),  32'(o_val[i]),  32'(m_val[i]));
            chk($sformatf("src%0d", i),  32'(o_src[i]),  32'(m_src[i]));
            chk($sformatf("done%0d", i), 32'(o_done[i]),
                32'(showing(i) && cyc == m_g[i] + H - 1));
        end
    endtask

    task automatic step(input logic [2:0] r, input logic [47:0] d);
        req  = r;
        data = d;
        advance(0);
        advance(1);
        @(posedge clk0);
        #1;
        cyc++;
        check_all();
    endtask

    // Reset is raised between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk0);
        #1;
        cyc++;
        check_all();
        rst = 1'b0;
    endtask

    function automatic logic [47:0] mk(input logic [15:0] d2, input logic [15:0] d1, input logic [15:0] d0);
        return {d2, d1, d0};
    endfunction

    logic [2:0]  r_rand;
    logic [47:0] d_rand;

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        bl[0]  = 2;
        bl[1]  = 0;
        rst    = 1'b1;
        req    = 3'b000;
        data   = '0;
        model_reset();
        @(posedge clk0);
        #1;
        cyc++;
        check_all();
        rst = 1'b0;

        // Single request from source 1
        step(3'b010, mk(16'h0000, 16'h1234, 16'h0000));
        chk("t1_gnt", 32'(gnt_a), 32'h2);
        chk("t1_val", 32'(val_a), 32'h1234);
        repeat (8) step(3'b000, mk(16'h0000, 16'h5555, 16'h0000));

        // Two sources requesting continuously alternate
        do_reset();
        repeat (22) step(3'b110, mk(16'hAAAA, 16'hBBBB, 16'hCCCC));

        // Source 0 preempts source 2 in its second SHOW cycle
        do_reset();
        repeat (5) step(3'b000, '0);
        step(3'b100, mk(16'hBEEF, 16'h0000, 16'h0000));
        step(3'b000, mk(16'hBEEF, 16'h0000, 16'h0000));
        step(3'b001, mk(16'h0000, 16'h0000, 16'hE001));
        chk("pre_val", 32'(val_a), 32'hE001);
        chk("pre_gnt", 32'(gnt_a), 32'h1);
        repeat (8) step(3'b000, mk(16'h0000, 16'h0000, 16'h7777));

        // Source 0 re-requesting while shown does not restart its hold
        step(3'b001, mk(16'h0000, 16'h0000, 16'h0A0A));
        step(3'b000, '0);
        step(3'b001, mk(16'h0000, 16'h0000, 16'h0B0B));
        step(3'b001, mk(16'h0000, 16'h0000, 16'h0B0B));
        repeat (8) step(3'b000, '0);

        // Back-to-back values: the zero-blank instance idles exactly one cycle
        step(3'b001, mk(16'h0000, 16'h2222, 16'h1111));
        repeat (3) step(3'b000, '0);
        repeat (6) step(3'b010, mk(16'h0000, 16'h2222, 16'h1111));
        repeat (8) step(3'b000, '0);

        // Asynchronous reset in the middle of SHOW
        step(3'b010, mk(16'h0000, 16'h4321, 16'h0000));
        step(3'b000, '0);
        step(3'b000, '0);
        do_reset();
        chk("rst_ena", 32'(ena_a), 32'h0);
        chk("rst_val", 32'(val_a), 32'h0);
        step(3'b111, mk(16'h3333, 16'h2222, 16'h1111));
        chk("rst_first_gnt", 32'(gnt_a), 32'h1);
        repeat (8) step(3'b000, '0);

        // Randomized traffic
        repeat (600) begin
            r_rand = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) r_rand = 3'b000;
            d_rand = {16'($urandom()), 32'($urandom())};
            if ($urandom_range(0, 150) == 0) begin
                do_reset();
            end else begin
                step(r_rand, d_rand);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
